// File: rtl/hazard3_sbus_to_ahb_pkg.sv
// Shared AHB-Lite encodings for the SBA-to-AHB responder.
// Contents:
//   HTRANS_*  transfer type encodings (IDLE, NONSEQ)
//   HBURST_*  burst encodings (SINGLE only; the responder never bursts)
//   HSIZE_*   transfer size encodings (byte, halfword, word)
package hazard3_sbus_to_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HALF    = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

endpackage

// File: rtl/hazard3_sbus_to_ahb_if.sv
// Bus bundles used by hazard3_sbus_to_ahb.
//   hazard3_sbus_if : debug-module system bus access channel
//     dbg_sbus_addr/write/size/vld/wdata  initiator -> responder
//     dbg_sbus_rdy/err/rdata              responder -> initiator
//     modports: master (debug module side), slave (bus responder side)
//   hazard3_ahb_if  : AHB-Lite manager port
//     haddr/hwrite/hsize/htrans/hburst/hprot/hmastlock/hwdata  manager -> subordinate
//     hready/hresp/hrdata                                       subordinate -> manager
//     modports: master (manager side), slave (subordinate side)
interface hazard3_sbus_if #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
);
  logic [W_ADDR-1:0] dbg_sbus_addr;
  logic              dbg_sbus_write;
  logic [1:0]        dbg_sbus_size;
  logic              dbg_sbus_vld;
  logic              dbg_sbus_rdy;
  logic              dbg_sbus_err;
  logic [W_DATA-1:0] dbg_sbus_wdata;
  logic [W_DATA-1:0] dbg_sbus_rdata;

  modport master (
    output dbg_sbus_addr, dbg_sbus_write, dbg_sbus_size, dbg_sbus_vld, dbg_sbus_wdata,
    input  dbg_sbus_rdy, dbg_sbus_err, dbg_sbus_rdata
  );

  modport slave (
    input  dbg_sbus_addr, dbg_sbus_write, dbg_sbus_size, dbg_sbus_vld, dbg_sbus_wdata,
    output dbg_sbus_rdy, dbg_sbus_err, dbg_sbus_rdata
  );
endinterface

interface hazard3_ahb_if #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
);
  logic [W_ADDR-1:0] haddr;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [1:0]        htrans;
  logic [2:0]        hburst;
  logic [3:0]        hprot;
  logic              hmastlock;
  logic [W_DATA-1:0] hwdata;
  logic              hready;
  logic              hresp;
  logic [W_DATA-1:0] hrdata;

  modport master (
    output haddr, hwrite, hsize, htrans, hburst, hprot, hmastlock, hwdata,
    input  hready, hresp, hrdata
  );

  modport slave (
    input  haddr, hwrite, hsize, htrans, hburst, hprot, hmastlock, hwdata,
    output hready, hresp, hrdata
  );
endinterface

// File: rtl/hazard3_sbus_to_ahb.sv
// Debug-module SBA responder on a dedicated AHB-Lite manager port.
// Takes one SBA transfer at a time and runs it as a single, non-pipelined
// AHB-Lite transfer (IDLE -> ADDR -> DATA -> IDLE), then returns the data
// phase result to the debug module.
// Ports:
//   clk    in  single clock, all state on posedge
//   rst_n  in  asynchronous active-low reset
//   sbus   hazard3_sbus_if.slave  SBA request/response channel
//   ahb    hazard3_ahb_if.master  AHB-Lite manager signals
// AHB address/control/write data are registered; the SBA completion
// (rdy/err/rdata) is decoded combinationally from state and hready/hresp.
module hazard3_sbus_to_ahb
  import hazard3_sbus_to_ahb_pkg::*;
#(
  parameter int          W_ADDR = 32,
  parameter int          W_DATA = 32,
  parameter logic [3:0]  HPROT  = 4'b0011
) (
  input  logic           clk,
  input  logic           rst_n,
  hazard3_sbus_if.slave  sbus,
  hazard3_ahb_if.master  ahb
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ADDR = 2'b01,
    S_DATA = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic [W_ADDR-1:0] haddr_q, haddr_d;
  logic              hwrite_q, hwrite_d;
  logic [2:0]        hsize_q, hsize_d;
  logic [1:0]        htrans_q, htrans_d;
  logic [W_DATA-1:0] hwdata_q, hwdata_d;
  logic [W_DATA-1:0] wdata_cap_q, wdata_cap_d;

  logic              rdy_s;
  logic              err_s;
  logic [W_DATA-1:0] rdata_s;

  // State and bus-side capture registers; reset drops any in-flight transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      haddr_q     <= {W_ADDR{1'b0}};
      hwrite_q    <= 1'b0;
      hsize_q     <= 3'b000;
      htrans_q    <= HTRANS_IDLE;
      hwdata_q    <= {W_DATA{1'b0}};
      wdata_cap_q <= {W_DATA{1'b0}};
    end else begin
      state_q     <= state_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      htrans_q    <= htrans_d;
      hwdata_q    <= hwdata_d;
      wdata_cap_q <= wdata_cap_d;
    end
  end

  // Next-state and next bus-control values.
  always_comb begin
    state_d     = state_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    hsize_d     = hsize_q;
    htrans_d    = htrans_q;
    hwdata_d    = hwdata_q;
    wdata_cap_d = wdata_cap_q;
    case (state_q)
      S_IDLE: begin
        if (sbus.dbg_sbus_vld) begin
          state_d     = S_ADDR;
          haddr_d     = sbus.dbg_sbus_addr;
          hwrite_d    = sbus.dbg_sbus_write;
          hsize_d     = {1'b0, sbus.dbg_sbus_size};
          htrans_d    = HTRANS_NONSEQ;
          // Write data is only presented once the address phase is accepted.
          wdata_cap_d = sbus.dbg_sbus_wdata;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADDR: begin
        if (ahb.hready) begin
          state_d  = S_DATA;
          htrans_d = HTRANS_IDLE;
          hwdata_d = wdata_cap_q;
        end else begin
          state_d = S_ADDR;
        end
      end
      S_DATA: begin
        // hready alone ends the data phase; the first error cycle (hready=0)
        // is just another wait here.
        if (ahb.hready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DATA;
        end
      end
      default: begin
        state_d  = S_IDLE;
        htrans_d = HTRANS_IDLE;
      end
    endcase
  end

  // SBA completion decode: only the last data-phase cycle reports.
  always_comb begin
    rdy_s   = 1'b0;
    err_s   = 1'b0;
    rdata_s = {W_DATA{1'b0}};
    if ((state_q == S_DATA) && ahb.hready) begin
      rdy_s = 1'b1;
      err_s = ahb.hresp;
      if (!ahb.hresp && !hwrite_q) begin
        rdata_s = ahb.hrdata;
      end else begin
        rdata_s = {W_DATA{1'b0}};
      end
    end else begin
      rdy_s   = 1'b0;
      err_s   = 1'b0;
      rdata_s = {W_DATA{1'b0}};
    end
  end

  assign sbus.dbg_sbus_rdy   = rdy_s;
  assign sbus.dbg_sbus_err   = err_s;
  assign sbus.dbg_sbus_rdata = rdata_s;

  assign ahb.haddr     = haddr_q;
  assign ahb.hwrite    = hwrite_q;
  assign ahb.hsize     = hsize_q;
  assign ahb.htrans    = htrans_q;
  assign ahb.hburst    = HBURST_SINGLE;
  assign ahb.hprot     = HPROT;
  assign ahb.hmastlock = 1'b0;
  assign ahb.hwdata    = hwdata_q;

endmodule

// File: tb/tb_hazard3_sbus_to_ahb.sv
// Directed self-checking bench for hazard3_sbus_to_ahb.
// Inputs are driven 1 ns after posedge; outputs are sampled 2 ns after posedge.
module tb_hazard3_sbus_to_ahb;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  hazard3_sbus_if #(.W_ADDR(32), .W_DATA(32)) sbus_if ();
  hazard3_ahb_if  #(.W_ADDR(32), .W_DATA(32)) ahb_if ();

  hazard3_sbus_to_ahb #(.W_ADDR(32), .W_DATA(32), .HPROT(4'b0011)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sbus  (sbus_if),
    .ahb   (ahb_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_quiet();
    sbus_if.dbg_sbus_vld   = 1'b0;
    sbus_if.dbg_sbus_addr  = 32'h0;
    sbus_if.dbg_sbus_write = 1'b0;
    sbus_if.dbg_sbus_size  = 2'd0;
    sbus_if.dbg_sbus_wdata = 32'h0;
    ahb_if.hready = 1'b1;
    ahb_if.hresp  = 1'b0;
    ahb_if.hrdata = 32'h0;
  endtask

  task automatic request(input logic [31:0] a, input logic w, input logic [1:0] s, input logic [31:0] wd);
    sbus_if.dbg_sbus_vld   = 1'b1;
    sbus_if.dbg_sbus_addr  = a;
    sbus_if.dbg_sbus_write = w;
    sbus_if.dbg_sbus_size  = s;
    sbus_if.dbg_sbus_wdata = wd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_quiet();
    #12;
    tests++; if (ahb_if.htrans !== 2'b00) begin fails++; $display("FAIL reset_htrans: got %h exp 0", ahb_if.htrans); end
    tests++; if (ahb_if.haddr !== 32'h0) begin fails++; $display("FAIL reset_haddr: got %h exp 0", ahb_if.haddr); end
    tests++; if (ahb_if.hwrite !== 1'b0 || ahb_if.hsize !== 3'd0) begin fails++; $display("FAIL reset_ctrl: got hwrite=%b hsize=%h exp 0/0", ahb_if.hwrite, ahb_if.hsize); end
    tests++; if (ahb_if.hwdata !== 32'h0) begin fails++; $display("FAIL reset_hwdata: got %h exp 0", ahb_if.hwdata); end
    tests++; if (sbus_if.dbg_sbus_rdy !== 1'b0 || sbus_if.dbg_sbus_err !== 1'b0) begin fails++; $display("FAIL reset_rdy_err: got %b/%b exp 0/0", sbus_if.dbg_sbus_rdy, sbus_if.dbg_sbus_err); end
    tests++; if (ahb_if.hburst !== 3'b000 || ahb_if.hprot !== 4'b0011 || ahb_if.hmastlock !== 1'b0) begin fails++; $display("FAIL const_ctrl: got hburst=%h hprot=%h hmastlock=%b exp 0/3/0", ahb_if.hburst, ahb_if.hprot, ahb_if.hmastlock); end
    #11;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read_word();
    request(32'h2000_0010, 1'b0, 2'd2, 32'h0);
    ahb_if.hrdata = 32'hDEAD_BEEF;
    #1;
    tests++; if (sbus_if.dbg_sbus_rdy !== 1'b0) begin fails++; $display("FAIL rd_c0_rdy: got %b exp 0", sbus_if.dbg_sbus_rdy); end
    tick(); #1;
    tests++; if (ahb_if.htrans !== 2'b10 || ahb_if.haddr !== 32'h2000_0010) begin fails++; $display("FAIL rd_c1_addr: got htrans=%h haddr=%h exp 2/20000010", ahb_if.htrans, ahb_if.haddr); end
    tests++; if (ahb_if.hsize !== 3'd2 || ahb_if.hwrite !== 1'b0) begin fails++; $display("FAIL rd_c1_ctrl: got hsize=%h hwrite=%b exp 2/0", ahb_if.hsize, ahb_if.hwrite); end
    tests++; if (sbus_if.dbg_sbus_rdy !== 1'b0) begin fails++; $display("FAIL rd_c1_rdy: got %b exp 0", sbus_if.dbg_sbus_rdy); end
    tick(); #1;
    tests++; if (sbus_if.dbg_sbus_rdy !== 1'b1 || sbus_if.dbg_sbus_err !== 1'b0) begin fails++; $display("FAIL rd_c2_rdy: got rdy=%b err=%b exp 1/0", sbus_if.dbg_sbus_rdy, sbus_if.dbg_sbus_err); end
    tests++; if (sbus_if.dbg_sbus_rdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rd_c2_rdata: got %h exp deadbeef", sbus_if.dbg_sbus_rdata); end
    tests++; if (ahb_if.htrans !== 2'b00) begin fails++; $display("FAIL rd_c2_htrans: got %h exp 0", ahb_if.htrans); end
    tick();
    bus_quiet();
    #1;
    tests++; if (sbus_if.dbg_sbus_rdy !== 1'b0 || sbus_if.dbg_sbus_rdata !== 32'h0) begin fails++; $display("FAIL rd_c3_idle: got rdy=%b rdata=%h exp 0/0", sbus_if.dbg_sbus_rdy, sbus_if.dbg_sbus_rdata); end
    tick();
  endtask

  task automatic test_write_byte();
    request(32'h0000_0013, 1'b1, 2'd0, 32'h00AB_0000);
    ahb_if.hrdata = 32'h1234_5678;
    tick(); #1;
    tests++; if (ahb_if.htrans !== 2'b10 || ahb_if.haddr !== 32'h13) begin fails++; $display("FAIL wr_c1_addr: got htrans=%h haddr=%h exp 2/13", ahb_if.htrans, ahb_if.haddr); end
    tests++; if (ahb_if.hsize !== 3'd0 || ahb_if.hwrite !== 1'b1) begin fails++; $display("FAIL wr_c1_ctrl: got hsize=%h hwrite=%b exp 0/1", ahb_if.hsize, ahb_if.hwrite); end
    tick(); #1;
    tests++; if (ahb_if.hwdata !== 32'h00AB_0000) begin fails++; $display("FAIL wr_c2_hwdata: got %h exp 00ab0000", ahb_if.hwdata); end
    tests++; if (sbus_if.dbg_sbus_rdy !== 1'b1 || sbus_if.dbg_sbus_err !== 1'b0) begin fails++; $display("FAIL wr_c2_rdy: got rdy=%b err=%b exp 1/0", sbus_if.dbg_sbus_rdy, sbus_if.dbg_sbus_err); end
    tests++; if (sbus_if.dbg_sbus_rdata !== 32'h0) begin fails++; $display("FAIL wr_c2_rdata: got %h exp 0", sbus_if.dbg_sbus_rdata); end
    tick();
    bus_quiet();
    tick();
  endtask

  task automatic test_wait_states();
    logic pat [1:7];
    pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    request(32'h4000_0008, 1'b1, 2'd2, 32'hCAFE_F00D);
    tick();
    for (int c = 1; c <= 7; c++) begin
      ahb_if.hready = pat[c];
      #1;
      tests++; if (sbus_if.dbg_sbus_rdy !== (c == 7)) begin fails++; $display("FAIL ws_rdy_c%0d: got %b exp %b", c, sbus_if.dbg_sbus_rdy, (c == 7)); end
      tests++; if (ahb_if.haddr !== 32'h4000_0008) begin fails++; $display("FAIL ws_haddr_c%0d: got %h exp 40000008", c, ahb_if.haddr); end
      tests++; if (ahb_if.htrans !== ((c <= 3) ? 2'b10 : 2'b00)) begin fails++; $display("FAIL ws_htrans_c%0d: got %h exp %h", c, ahb_if.htrans, ((c <= 3) ? 2'b10 : 2'b00)); end
      if (c >= 4) begin
        tests++; if (ahb_if.hwdata !== 32'hCAFE_F00D) begin fails++; $display("FAIL ws_hwdata_c%0d: got %h exp cafef00d", c, ahb_if.hwdata); end
      end
      tick();
    end
    bus_quiet();
    tick();
  endtask

  task automatic test_error();
    request(32'h0000_0100, 1'b0, 2'd2, 32'h0);
    ahb_if.hrdata = 32'h5555_AAAA;
    tick();
    tick();
    ahb_if.hready = 1'b0;
    ahb_if.hresp  = 1'b1;
    #1;
    tests++; if (sbus_if.dbg_sbus_rdy !== 1'b0 || sbus_if.dbg_sbus_err !== 1'b0) begin fails++; $display("FAIL err_first: got rdy=%b err=%b exp 0/0", sbus_if.dbg_sbus_rdy, sbus_if.dbg_sbus_err); end
    tick();
    ahb_if.hready = 1'b1;
    ahb_if.hresp  = 1'b1;
    #1;
    tests++; if (sbus_if.dbg_sbus_rdy !== 1'b1 || sbus_if.dbg_sbus_err !== 1'b1) begin fails++; $display("FAIL err_second: got rdy=%b err=%b exp 1/1", sbus_if.dbg_sbus_rdy, sbus_if.dbg_sbus_err); end
    tests++; if (sbus_if.dbg_sbus_rdata !== 32'h0) begin fails++; $display("FAIL err_rdata: got %h exp 0", sbus_if.dbg_sbus_rdata); end
    tick();
    bus_quiet();
    #1;
    tests++; if (sbus_if.dbg_sbus_rdy !== 1'b0 || ahb_if.htrans !== 2'b00) begin fails++; $display("FAIL err_after: got rdy=%b htrans=%h exp 0/0", sbus_if.dbg_sbus_rdy, ahb_if.htrans); end
    tick();
  endtask

  task automatic test_back_to_back();
    int nonseq_cnt;
    nonseq_cnt = 0;
    request(32'h0000_0200, 1'b0, 2'd2, 32'h0);
    ahb_if.hrdata = 32'h0BAD_F00D;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 3) request(32'h0000_0300, 1'b1, 2'd1, 32'h0000_BEEF);
      if (c == 6) sbus_if.dbg_sbus_vld = 1'b0;
      #1;
      if (ahb_if.htrans == 2'b10) nonseq_cnt++;
      tests++; if (sbus_if.dbg_sbus_rdy !== ((c == 2) || (c == 5))) begin fails++; $display("FAIL b2b_rdy_c%0d: got %b exp %b", c, sbus_if.dbg_sbus_rdy, ((c == 2) || (c == 5))); end
      tests++; if (ahb_if.htrans !== (((c == 1) || (c == 4)) ? 2'b10 : 2'b00)) begin fails++; $display("FAIL b2b_htrans_c%0d: got %h exp %h", c, ahb_if.htrans, (((c == 1) || (c == 4)) ? 2'b10 : 2'b00)); end
      if (c == 4) begin
        tests++; if (ahb_if.haddr !== 32'h300 || ahb_if.hwrite !== 1'b1 || ahb_if.hsize !== 3'd1) begin fails++; $display("FAIL b2b_second_addr: got haddr=%h hwrite=%b hsize=%h exp 300/1/1", ahb_if.haddr, ahb_if.hwrite, ahb_if.hsize); end
      end
      if (c == 5) begin
        tests++; if (ahb_if.hwdata !== 32'h0000_BEEF || sbus_if.dbg_sbus_rdata !== 32'h0) begin fails++; $display("FAIL b2b_second_data: got hwdata=%h rdata=%h exp beef/0", ahb_if.hwdata, sbus_if.dbg_sbus_rdata); end
      end
    end
    tests++; if (nonseq_cnt != 2) begin fails++; $display("FAIL b2b_issue_count: got %0d exp 2", nonseq_cnt); end
    bus_quiet();
    tick();
  endtask

  task automatic test_reset_mid();
    request(32'h0000_0500, 1'b1, 2'd2, 32'h7777_0000);
    tick();
    tick();
    ahb_if.hready = 1'b0;
    #1;
    tests++; if (sbus_if.dbg_sbus_rdy !== 1'b0 || ahb_if.hwdata !== 32'h7777_0000) begin fails++; $display("FAIL rst_pre: got rdy=%b hwdata=%h exp 0/77770000", sbus_if.dbg_sbus_rdy, ahb_if.hwdata); end
    rst_n = 1'b0;
    sbus_if.dbg_sbus_vld = 1'b0;
    ahb_if.hready = 1'b1;
    #1;
    tests++; if (ahb_if.htrans !== 2'b00 || ahb_if.haddr !== 32'h0 || ahb_if.hwdata !== 32'h0) begin fails++; $display("FAIL rst_mid_bus: got htrans=%h haddr=%h hwdata=%h exp 0/0/0", ahb_if.htrans, ahb_if.haddr, ahb_if.hwdata); end
    tests++; if (sbus_if.dbg_sbus_rdy !== 1'b0 || ahb_if.hwrite !== 1'b0) begin fails++; $display("FAIL rst_mid_rdy: got rdy=%b hwrite=%b exp 0/0", sbus_if.dbg_sbus_rdy, ahb_if.hwrite); end
    tick();
    tests++; if (sbus_if.dbg_sbus_rdy !== 1'b0) begin fails++; $display("FAIL rst_held_rdy: got %b exp 0", sbus_if.dbg_sbus_rdy); end
    #3;
    rst_n = 1'b1;
    tick();
    request(32'h0000_0600, 1'b0, 2'd2, 32'h0);
    ahb_if.hrdata = 32'h0600_0600;
    tick(); #1;
    tests++; if (ahb_if.htrans !== 2'b10 || ahb_if.haddr !== 32'h600) begin fails++; $display("FAIL rst_new_addr: got htrans=%h haddr=%h exp 2/600", ahb_if.htrans, ahb_if.haddr); end
    tick(); #1;
    tests++; if (sbus_if.dbg_sbus_rdy !== 1'b1 || sbus_if.dbg_sbus_rdata !== 32'h0600_0600) begin fails++; $display("FAIL rst_new_done: got rdy=%b rdata=%h exp 1/06000600", sbus_if.dbg_sbus_rdy, sbus_if.dbg_sbus_rdata); end
    tick();
    bus_quiet();
    tick();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_read_word();
    test_write_byte();
    test_wait_states();
    test_error();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
